// File: rtl/xor_memory_pkg.sv
// Shared types for the conflict-aware multi-port memory scheduler.
package xor_memory_pkg;

  localparam int unsigned REQ_ID_W = 8;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  typedef struct packed {
    logic                valid;
    logic [REQ_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/xor_memory_rr_scan.sv
// Combinational round-robin scan granting up to PORTS non-conflicting requests per cycle.
module xor_memory_rr_scan
  import xor_memory_pkg::*;
#(
  parameter  int REQS  = 4,
  parameter  int PORTS = 2,
  parameter  int AW    = 8,
  localparam int IDW   = (REQS > 1) ? $clog2(REQS) : 1
) (
  input  logic [IDW-1:0]  ptr_i,
  input  logic [REQS-1:0] valid_i,
  input  logic [REQS-1:0] we_i,
  input  logic [AW-1:0]   addr_i     [REQS],
  output logic [REQS-1:0] grant_o,
  output logic [PORTS-1:0] port_vld_o,
  output logic [IDW-1:0]  port_id_o  [PORTS],
  output logic [IDW-1:0]  next_ptr_o
);

  always_comb begin
    logic [REQS-1:0] gnt;
    logic [IDW:0]    sum;
    logic [IDW-1:0]  idx;
    logic            clash;
    int unsigned     cnt;

    gnt        = '0;
    port_vld_o = '0;
    next_ptr_o = ptr_i;
    sum        = '0;
    idx        = '0;
    clash      = 1'b0;
    cnt        = 0;
    for (int unsigned p = 0; p < PORTS; p++) port_id_o[p] = '0;

    for (int unsigned j = 0; j < REQS; j++) begin
      sum = {1'b0, ptr_i} + (IDW+1)'(j);
      if (sum >= (IDW+1)'(REQS)) sum = sum - (IDW+1)'(REQS);
      idx = sum[IDW-1:0];

      // A pair clashes only on equal address with at least one writer.
      clash = 1'b0;
      for (int unsigned q = 0; q < REQS; q++) begin
        if (gnt[q] && (addr_i[q] == addr_i[idx]) &&
            ((op_e'(we_i[q]) == OP_WRITE) || (op_e'(we_i[idx]) == OP_WRITE)))
          clash = 1'b1;
      end

      if (valid_i[idx] && !clash && (cnt < PORTS)) begin
        gnt[idx] = 1'b1;
        for (int unsigned p = 0; p < PORTS; p++) begin
          if (p == cnt) begin
            port_vld_o[p] = 1'b1;
            port_id_o[p]  = idx;
          end
        end
        cnt        = cnt + 1;
        next_ptr_o = (idx == IDW'(REQS - 1)) ? '0 : idx + IDW'(1);
      end
    end

    grant_o = gnt;
  end

endmodule

// File: rtl/xor_memory_sched.sv
// Multi-port memory scheduler: round-robin grants, port muxing and per-port read tag pipelines.
module xor_memory_sched
  import xor_memory_pkg::*;
#(
  parameter  int WIDTH    = 8,
  parameter  int DEPTH    = 256,
  parameter  int PORTS    = 2,
  parameter  int REQS     = 4,
  parameter  int READ_LAT = 1,
  localparam int AW       = $clog2(DEPTH),
  localparam int IDW      = (REQS > 1) ? $clog2(REQS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REQS-1:0]  req_valid,
  output logic [REQS-1:0]  req_ready,
  input  logic [REQS-1:0]  req_we,
  input  logic [AW-1:0]    req_addr  [REQS],
  input  logic [WIDTH-1:0] req_wdata [REQS],
  output logic [REQS-1:0]  rsp_valid,
  output logic [WIDTH-1:0] rsp_rdata [REQS],
  output logic [AW-1:0]    mem_addr  [PORTS],
  output logic [WIDTH-1:0] mem_d     [PORTS],
  output logic [PORTS-1:0] mem_en,
  input  logic [WIDTH-1:0] mem_q     [PORTS]
);

  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [REQS-1:0]  vld_m, gnt;
  logic [PORTS-1:0] port_vld;
  logic [IDW-1:0]   port_id [PORTS];
  logic [IDW-1:0]   next_ptr;
  tag_t             tag_in  [PORTS];
  tag_t             tag_q   [PORTS][READ_LAT];

  // Masking valids during reset keeps grants, memory drives and tags quiet.
  assign vld_m = rst ? '0 : req_valid;

  xor_memory_rr_scan #(
    .REQS  (REQS),
    .PORTS (PORTS),
    .AW    (AW)
  ) u_scan (
    .ptr_i      (ptr_q),
    .valid_i    (vld_m),
    .we_i       (req_we),
    .addr_i     (req_addr),
    .grant_o    (gnt),
    .port_vld_o (port_vld),
    .port_id_o  (port_id),
    .next_ptr_o (next_ptr)
  );

  assign req_ready = gnt;
  assign ptr_d     = (|gnt) ? next_ptr : ptr_q;

  always_comb begin
    for (int unsigned k = 0; k < PORTS; k++) begin
      mem_addr[k] = '0;
      mem_d[k]    = '0;
      mem_en[k]   = 1'b0;
      tag_in[k]   = '0;
      if (port_vld[k]) begin
        mem_addr[k]     = req_addr[port_id[k]];
        mem_d[k]        = req_wdata[port_id[k]];
        mem_en[k]       = req_we[port_id[k]];
        tag_in[k].valid = ~req_we[port_id[k]];
        tag_in[k].id    = REQ_ID_W'(port_id[k]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
      for (int unsigned k = 0; k < PORTS; k++)
        for (int unsigned s = 0; s < READ_LAT; s++)
          tag_q[k][s] <= '0;
    end else begin
      ptr_q <= ptr_d;
      for (int unsigned k = 0; k < PORTS; k++) begin
        tag_q[k][0] <= tag_in[k];
        for (int unsigned s = 1; s < READ_LAT; s++)
          tag_q[k][s] <= tag_q[k][s-1];
      end
    end
  end

  // At most one tag per requester exits per cycle, so the writes below never collide.
  always_comb begin
    logic [IDW-1:0] rid;
    rid       = '0;
    rsp_valid = '0;
    for (int unsigned i = 0; i < REQS; i++) rsp_rdata[i] = '0;
    for (int unsigned k = 0; k < PORTS; k++) begin
      if (tag_q[k][READ_LAT-1].valid) begin
        rid            = tag_q[k][READ_LAT-1].id[IDW-1:0];
        rsp_valid[rid] = 1'b1;
        rsp_rdata[rid] = mem_q[k];
      end
    end
  end

endmodule

// File: tb/tb_xor_memory_sched.sv
// Directed self-checking bench for xor_memory_sched with a one-cycle-latency memory model.
module tb_xor_memory_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req_valid, req_ready, req_we, rsp_valid;
  logic [7:0] req_addr  [4];
  logic [7:0] req_wdata [4];
  logic [7:0] rsp_rdata [4];
  logic [7:0] mem_addr  [2];
  logic [7:0] mem_d     [2];
  logic [7:0] mem_q     [2];
  logic [1:0] mem_en;
  logic [7:0] mem [256];

  int n_tests = 0;
  int n_fail  = 0;
  int gcount [4];

  always #5 clk = ~clk;

  xor_memory_sched #(
    .WIDTH    (8),
    .DEPTH    (256),
    .PORTS    (2),
    .REQS     (4),
    .READ_LAT (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .mem_addr  (mem_addr),
    .mem_d     (mem_d),
    .mem_en    (mem_en),
    .mem_q     (mem_q)
  );

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (mem_en[k]) mem[mem_addr[k]] <= mem_d[k];
      mem_q[k] <= mem[mem_addr[k]];
    end
  end

  function automatic logic [7:0] init_val(input int a);
    return 8'(a) ^ 8'h5A;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input int i, input logic we, input logic [7:0] a, input logic [7:0] d);
    req_valid[i] = 1'b1;
    req_we[i]    = we;
    req_addr[i]  = a;
    req_wdata[i] = d;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = init_val(i);
    mem_q[0] = '0;
    mem_q[1] = '0;
    rst       = 1'b1;
    req_valid = '0;
    req_we    = '0;
    for (int i = 0; i < 4; i++) begin
      req_addr[i]  = '0;
      req_wdata[i] = '0;
    end

    // Reset with writes presented: nothing may reach the memory.
    #1;
    for (int i = 0; i < 4; i++) req(i, 1'b1, 8'(8'h60 + i), 8'h11);
    #2;
    check("rst_ready",  32'(req_ready), 32'h0);
    check("rst_mem_en", 32'(mem_en), 32'h0);
    check("rst_addr0",  32'(mem_addr[0]), 32'h0);
    check("rst_d0",     32'(mem_d[0]), 32'h0);
    check("rst_rsp",    32'(rsp_valid), 32'h0);
    check("rst_ptr",    32'(dut.ptr_q), 32'h0);
    cyc();
    cyc();

    // Four reads from ptr 0
    rst = 1'b0;
    for (int i = 0; i < 4; i++) req(i, 1'b0, 8'(8'h10 + i), 8'h00);
    #2;
    check("A_ready0", 32'(req_ready), 32'b0011);
    check("A_addr0",  32'(mem_addr[0]), 32'h10);
    check("A_addr1",  32'(mem_addr[1]), 32'h11);
    check("A_en0",    32'(mem_en), 32'h0);
    cyc();
    req_valid[0] = 1'b0;
    req_valid[1] = 1'b0;
    #2;
    check("A_ready1", 32'(req_ready), 32'b1100);
    check("A_addr0b", 32'(mem_addr[0]), 32'h12);
    check("A_addr1b", 32'(mem_addr[1]), 32'h13);
    check("A_rsp1",   32'(rsp_valid), 32'b0011);
    check("A_rd0",    32'(rsp_rdata[0]), 32'(init_val(8'h10)));
    check("A_rd1",    32'(rsp_rdata[1]), 32'(init_val(8'h11)));
    cyc();
    req_valid = '0;
    #2;
    check("A_rsp2",   32'(rsp_valid), 32'b1100);
    check("A_rd2",    32'(rsp_rdata[2]), 32'(init_val(8'h12)));
    check("A_rd3",    32'(rsp_rdata[3]), 32'(init_val(8'h13)));
    check("A_rd0_zero", 32'(rsp_rdata[0]), 32'h0);
    check("A_ptr",    32'(dut.ptr_q), 32'h0);
    cyc();
    #2;
    check("A_rsp3",   32'(rsp_valid), 32'h0);

    // Write/read conflict on 0x20
    cyc();
    req(0, 1'b1, 8'h20, 8'hA5);
    req(1, 1'b0, 8'h20, 8'h00);
    #2;
    check("B_ready0", 32'(req_ready), 32'b0001);
    check("B_en0",    32'(mem_en), 32'b01);
    check("B_addr0",  32'(mem_addr[0]), 32'h20);
    check("B_d0",     32'(mem_d[0]), 32'hA5);
    check("B_addr1",  32'(mem_addr[1]), 32'h0);
    cyc();
    req_valid[0] = 1'b0;
    #2;
    check("B_ready1", 32'(req_ready), 32'b0010);
    check("B_addr0b", 32'(mem_addr[0]), 32'h20);
    check("B_en1",    32'(mem_en), 32'h0);
    cyc();
    req_valid[1] = 1'b0;
    #2;
    check("B_rsp",    32'(rsp_valid), 32'b0010);
    check("B_rd1",    32'(rsp_rdata[1]), 32'hA5);
    check("B_ptr",    32'(dut.ptr_q), 32'h2);

    // Two reads of the same address share a cycle (ptr 2)
    cyc();
    req(0, 1'b0, 8'h30, 8'h00);
    req(1, 1'b0, 8'h30, 8'h00);
    #2;
    check("C_ready",  32'(req_ready), 32'b0011);
    check("C_addr0",  32'(mem_addr[0]), 32'h30);
    check("C_addr1",  32'(mem_addr[1]), 32'h30);
    cyc();
    req_valid = '0;
    #2;
    check("C_rsp",    32'(rsp_valid), 32'b0011);
    check("C_rd0",    32'(rsp_rdata[0]), 32'(init_val(8'h30)));
    check("C_rd1",    32'(rsp_rdata[1]), 32'(init_val(8'h30)));
    check("C_ptr",    32'(dut.ptr_q), 32'h2);

    // Lone r3 write, ptr wraps to 0
    cyc();
    req(3, 1'b1, 8'hFF, 8'h3C);
    #2;
    check("E_ready",  32'(req_ready), 32'b1000);
    check("E_addr0",  32'(mem_addr[0]), 32'hFF);
    check("E_d0",     32'(mem_d[0]), 32'h3C);
    check("E_en",     32'(mem_en), 32'b01);
    check("E_addr1",  32'(mem_addr[1]), 32'h0);
    check("E_d1",     32'(mem_d[1]), 32'h0);
    cyc();
    req_valid = '0;
    #2;
    check("E_ptr",    32'(dut.ptr_q), 32'h0);
    check("E_rsp",    32'(rsp_valid), 32'h0);

    // All requesters continuously valid for 8 cycles
    cyc();
    for (int i = 0; i < 4; i++) begin
      gcount[i] = 0;
      req(i, 1'b0, 8'(8'h40 + i), 8'h00);
    end
    for (int c = 0; c < 8; c++) begin
      #2;
      check("D_ptr",   32'(dut.ptr_q), (c % 2 == 0) ? 32'h0 : 32'h2);
      check("D_ready", 32'(req_ready), (c % 2 == 0) ? 32'b0011 : 32'b1100);
      for (int i = 0; i < 4; i++) if (req_ready[i]) gcount[i]++;
      cyc();
    end
    req_valid = '0;
    for (int i = 0; i < 4; i++) check("D_cnt", 32'(gcount[i]), 32'd4);

    // Reset with two reads outstanding
    req(0, 1'b0, 8'h50, 8'h00);
    req(1, 1'b0, 8'h51, 8'h00);
    #2;
    check("F_ready",  32'(req_ready), 32'b0011);
    cyc();
    req_valid = '0;
    rst = 1'b1;
    req(2, 1'b1, 8'h60, 8'h77);
    #2;
    check("F_rsp_rst",   32'(rsp_valid), 32'h0);
    check("F_en_rst",    32'(mem_en), 32'h0);
    check("F_ready_rst", 32'(req_ready), 32'h0);
    check("F_ptr_rst",   32'(dut.ptr_q), 32'h0);
    cyc();
    #2;
    check("F_rsp_rst2",  32'(rsp_valid), 32'h0);
    rst = 1'b0;
    req_valid = '0;
    req(1, 1'b0, 8'h70, 8'h00);
    req(2, 1'b0, 8'h71, 8'h00);
    req(3, 1'b0, 8'h72, 8'h00);
    #2;
    check("F_ready_rel", 32'(req_ready), 32'b0110);
    check("F_rsp_rel",   32'(rsp_valid), 32'h0);
    cyc();
    req_valid = '0;
    #2;
    check("F_rsp_new",   32'(rsp_valid), 32'b0110);
    check("F_rd1",       32'(rsp_rdata[1]), 32'(init_val(8'h70)));
    check("F_rd2",       32'(rsp_rdata[2]), 32'(init_val(8'h71)));
    cyc();
    #2;
    check("F_rsp_end",   32'(rsp_valid), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
